// File: rtl/note_history_buf.sv
// note_history_buf: records each new piano note press into a 4-deep history
// (newest on p0) for the scanning display, with freeze, clear and idle
// auto-blank. Every output is a register, so the scanner may sample at any time.
module note_history_buf #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned CW             = 32,
  parameter logic [4:0]  BLANK          = 5'd31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_code,
  input  logic       freeze,
  input  logic       clear,
  output logic [4:0] p0,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic [4:0] p3,
  output logic [2:0] depth,
  output logic       note_pushed,
  output logic       timed_out
);

  localparam int unsigned KW = 5;
  localparam int unsigned DW = 3;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(4);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] latched_q, latched_d;
  logic [KW-1:0] p0_q, p1_q, p2_q, p3_q;
  logic [KW-1:0] p0_d, p1_d, p2_d, p3_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pushed_q, pushed_d;
  logic          to_q, to_d;

  logic [KW-1:0] key_c;
  logic          push_req_c;
  logic          cnt_inc_c;

  // Code 31 (and 0) both mean "no key"; only 1..30 are real notes.
  assign key_c = (key_code != '0 && key_code != KW'(31)) ? key_code : '0;

  // Press/legato detector: tracks the held key regardless of freeze or clear.
  always_comb begin
    state_d    = state_q;
    latched_d  = latched_q;
    push_req_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_c != '0) begin
          state_d    = HELD;
          latched_d  = key_c;
          push_req_c = 1'b1;
        end
      end
      HELD: begin
        if (key_c == '0) begin
          state_d = IDLE;
        end else if (key_c != latched_q) begin
          latched_d  = key_c;
          push_req_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // History, depth, idle counter and pulses; clear beats push beats timeout.
  always_comb begin
    p0_d      = p0_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    depth_d   = depth_q;
    cnt_d     = cnt_q;
    pushed_d  = 1'b0;
    to_d      = 1'b0;
    cnt_inc_c = (state_q == IDLE) && (depth_q != '0) && !freeze;
    if (clear) begin
      p0_d    = BLANK;
      p1_d    = BLANK;
      p2_d    = BLANK;
      p3_d    = BLANK;
      depth_d = '0;
      cnt_d   = '0;
    end else if (push_req_c && !freeze) begin
      p3_d     = p2_q;
      p2_d     = p1_q;
      p1_d     = p0_q;
      p0_d     = key_c;
      depth_d  = (depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_q + DW'(1);
      pushed_d = 1'b1;
      cnt_d    = '0;
    end else if (state_q == HELD) begin
      cnt_d = '0;
    end else if (cnt_inc_c) begin
      if (cnt_q == CNT_LAST) begin
        p0_d    = BLANK;
        p1_d    = BLANK;
        p2_d    = BLANK;
        p3_d    = BLANK;
        depth_d = '0;
        cnt_d   = '0;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      latched_q <= '0;
      p0_q      <= BLANK;
      p1_q      <= BLANK;
      p2_q      <= BLANK;
      p3_q      <= BLANK;
      depth_q   <= '0;
      cnt_q     <= '0;
      pushed_q  <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      depth_q   <= depth_d;
      cnt_q     <= cnt_d;
      pushed_q  <= pushed_d;
      to_q      <= to_d;
    end
  end

  assign p0          = p0_q;
  assign p1          = p1_q;
  assign p2          = p2_q;
  assign p3          = p3_q;
  assign depth       = depth_q;
  assign note_pushed = pushed_q;
  assign timed_out   = to_q;

endmodule

// File: doc/note_history_buf.md
Name: note_history_buf

Overview:
- Upstream feeder for the 4-digit scanning display stage; drives its p0..p3 5-bit display-code inputs.
- Watches the live piano key code and records each new note press into a 4-deep history, newest on p0.
- Supports freeze (hold the display during replay), manual clear, and auto-blank after an idle timeout.
- All outputs are registered and stable between pushes, so the scanner can sample them at any time.

Parameters:
- TIMEOUT_CYCLES, 500000000, number of idle clk cycles before the history auto-clears (5 s at 100 MHz); legal range 2..2^CW-1.
- CW, 32, width of the idle counter.
- BLANK, 5'd31, display code rendered as all segments off.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous reset, active-high
- key_code  in  5  live key code; 0 = no key; 1..30 = note; 31 is treated as no key
- freeze  in  1  level; high blocks pushes and holds the idle counter
- clear  in  1  single-cycle pulse; blanks the history
- p0  out  5  newest note code, registered
- p1  out  5  second newest note code, registered
- p2  out  5  third newest note code, registered
- p3  out  5  oldest note code, registered
- depth  out  3  number of valid entries, 0..4, saturating
- note_pushed  out  1  one-cycle pulse on the edge a push occurs
- timed_out  out  1  one-cycle pulse on the edge the auto-clear fires

Behaviour:
- Only one clock domain exists; reset is synchronous and active-high on clk.
- Reset values: p0..p3 = BLANK, depth = 0, note_pushed = 0, timed_out = 0, FSM = IDLE, latched code = 0, idle counter = 0.
- key is defined as key_code when key_code is in 1..30, else 0.
- FSM states:
  - IDLE: no key held.
  - HELD: a key is held; the latched code holds its value.
- FSM transitions, evaluated every cycle, including while freeze or clear is high:
  - IDLE, key != 0: go to HELD, latch key, raise the push request.
  - HELD, key == 0: go to IDLE.
  - HELD, key != 0 and key != latched: stay in HELD, latch key, raise the push request (legato).
  - HELD, key == latched: no action.
- A push happens when the push request is raised, freeze = 0 and clear = 0.
- On a push:
  - Shift the history: p3<=p2, p2<=p1, p1<=p0, p0<=key.
  - depth <= min(depth+1, 4).
  - Set note_pushed = 1 for that cycle only.
  - Idle counter <= 0.
- Push latency: p0 shows the new code on the first clk edge that samples the new key_code; visible one cycle after key_code changes.
- A request that is blocked by freeze or clear is dropped, not queued.
  - A key held across freeze release is not pushed; it is pushed only when a new press occurs.
  - Because the FSM keeps tracking during freeze, the latched code always reflects the current key.
- Clear (clear = 1):
  - p0..p3 <= BLANK, depth <= 0, idle counter <= 0.
  - Clear has priority over a same-cycle push and over a same-cycle timeout.
  - timed_out stays 0 in that cycle.
- Idle counter:
  - Increments only when FSM = IDLE, depth != 0 and freeze = 0.
  - Held at 0 in HELD.
  - Frozen (holds its value) while freeze = 1.
- Timeout: when the counter equals TIMEOUT_CYCLES-1 and would increment:
  - p0..p3 <= BLANK, depth <= 0, counter <= 0.
  - Set timed_out = 1 for one cycle.
  - Blanking occurs exactly TIMEOUT_CYCLES cycles after the release edge that produced IDLE.
- depth saturates at 4; older entries fall off p3 with no indication.
- Reset mid-hold: after rst deasserts the FSM is IDLE. A key still held is pushed on the first cycle after reset.
- Repeatedly pressing the same note pushes it again each time, provided a release (key == 0) occurs in between.

Test Plan:
1. Reset with key_code = 0 -> p0..p3 = 31, depth = 0, no pulses.
2. Press codes 3, 0, 5, 0, 7, 0, 9, 0, 11, each held 4 cycles -> p0..p3 = 11, 9, 7, 5; depth = 4; five note_pushed pulses; each p0 update one cycle after the key_code change.
3. Legato: key_code 3 then directly 5, no release between -> two pushes, p0 = 5, p1 = 3.
4. Freeze:
   - Set freeze = 1, press 8, release.
   - Then press 12 and hold while dropping freeze.
   - Release 12 and press 14 -> display unchanged until 14 is pushed to p0; 8 and 12 are never pushed.
5. clear:
   - Pulse clear while history = 3, 5 -> all p = 31, depth = 0.
   - Pulse clear in the same cycle as a press of 6 -> still blank; holding 6 produces no later push.
6. TIMEOUT_CYCLES = 8:
   - Push 4, release -> timed_out pulses 8 cycles after the release edge, p0 = 31, depth = 0.
   - Press again 3 cycles after a release -> counter restarts from 0.
   - Freeze for 5 cycles -> timeout is delayed by 5 cycles.
